dmem_bridge: RTL and testbench

Data-side memory responder for the pipelined MIPS core: answers the core's memory-stage access (memwriteM, aluoutM, writedataM, readdataM) with a word RAM and a small memory-mapped register file. The register file holds a 64-bit cycle counter, a down-counting timer with interrupt, and a GPIO output register. Reads are combinational so the memory stage completes in one cycle without stalls. Writes commit on the rising clock edge.

---
 rtl/dmem_bridge_pkg.sv | 24 ++
 rtl/dmem_timer.sv | 69 ++++++
 rtl/dmem_bridge.sv | 115 +++++++++++
 tb/tb_dmem_bridge.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared decode constants for the data-side memory bridge: region codes,
// MMIO word offsets and TIMER_CTRL bit positions.
package dmem_bridge_pkg;

    localparam logic [3:0]  REGION_RAM  = 4'h0;
    localparam logic [3:0]  REGION_MMIO = 4'h1;
    localparam logic [31:0] MMIO_BASE   = 32'h1000_0000;

    // Word offsets within the MMIO window, taken from address bits [4:2].
    typedef enum logic [2:0] {
        OFF_CYCLE_LO   = 3'd0,
        OFF_CYCLE_HI   = 3'd1,
        OFF_TIMER_CNT  = 3'd2,
        OFF_TIMER_CTRL = 3'd3,
        OFF_TIMER_LOAD = 3'd4,
        OFF_GPIO_OUT   = 3'd5
    } mmio_off_e;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_FLAG       = 2;
    localparam int CTRL_IRQ_EN     = 3;

endpackage

// File: rtl/dmem_timer.sv
// Down-counting timer with optional autoreload and a sticky expiry flag that
// drives the interrupt when irq_en is set.
module dmem_timer
    import dmem_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cnt_we,
    input  logic        ctrl_we,
    input  logic        load_we,
    input  logic [31:0] wdata,
    output logic [31:0] cnt,
    output logic [31:0] load,
    output logic [31:0] ctrl,
    output logic        irq
);

    logic en;
    logic autoreload;
    logic flag;
    logic irq_en;
    logic expire;

    assign expire = en && (cnt == 32'd1);

    // NOTE: state registers use non-blocking assignments so every branch
    // below sees the pre-edge values of cnt, load and flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            load       <= '0;
            en         <= 1'b0;
            autoreload <= 1'b0;
            flag       <= 1'b0;
            irq_en     <= 1'b0;
        end else begin
            if (cnt_we) begin
                cnt <= wdata;
            end else if (en && cnt != '0) begin
                cnt <= expire ? (autoreload ? load : '0) : cnt - 32'd1;
            end
            if (load_we) begin
                load <= wdata;
            end
            if (ctrl_we) begin
                en         <= wdata[CTRL_EN];
                autoreload <= wdata[CTRL_AUTORELOAD];
                irq_en     <= wdata[CTRL_IRQ_EN];
            end
            // Expiry outranks a same-cycle write-1-to-clear.
            if (expire) begin
                flag <= 1'b1;
            end else if (ctrl_we && wdata[CTRL_FLAG]) begin
                flag <= 1'b0;
            end
        end
    end

    always_comb begin
        ctrl                  = '0;
        ctrl[CTRL_EN]         = en;
        ctrl[CTRL_AUTORELOAD] = autoreload;
        ctrl[CTRL_FLAG]       = flag;
        ctrl[CTRL_IRQ_EN]     = irq_en;
    end

    assign irq = flag && irq_en;

endmodule

// File: rtl/dmem_bridge.sv
// Memory-stage data responder: word RAM plus MMIO cycle counter, timer and GPIO.
// Define DMEM_TIMER_EN to build the timer; otherwise its slots read 0 and ignore writes.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int RAM_WORDS = 1024,
    parameter int GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memwriteM,
    input  logic [31:0]       aluoutM,
    input  logic [31:0]       writedataM,
    output logic [31:0]       readdataM,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq,
    output logic              bus_err
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

    logic [31:0]       ram [RAM_WORDS];
    logic [63:0]       cycle_cnt;
    logic [GPIO_W-1:0] gpio_q;
    logic              bus_err_q;
    logic [31:0]       tmr_cnt;
    logic [31:0]       tmr_load;
    logic [31:0]       tmr_ctrl;

    logic          ram_hit;
    logic          mmio_hit;
    logic          illegal_wr;
    logic          wr_ok;
    logic [2:0]    off;
    logic [AW-1:0] word_idx;

    assign word_idx = aluoutM[2 +: AW];
    assign off      = aluoutM[4:2];
    assign ram_hit  = (aluoutM[31:28] == REGION_RAM) && ({4'h0, aluoutM[27:0]} < RAM_BYTES);
    assign mmio_hit = (aluoutM[31:5] == MMIO_BASE[31:5]);

    // Cycle-counter slots are read-only; unused MMIO slots silently absorb writes.
    assign illegal_wr = memwriteM && ((aluoutM[1:0] != 2'b00) || !(ram_hit || mmio_hit) ||
                        (mmio_hit && (off == OFF_CYCLE_LO || off == OFF_CYCLE_HI)));
    assign wr_ok      = memwriteM && !illegal_wr && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            gpio_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (wr_ok && mmio_hit && off == OFF_GPIO_OUT) begin
                gpio_q <= writedataM[GPIO_W-1:0];
            end
            if (illegal_wr) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // NOTE: the RAM array has no reset branch; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_ok && ram_hit) begin
            ram[word_idx] <= writedataM;
        end
    end

`ifdef DMEM_TIMER_EN
    logic tmr_wr;
    assign tmr_wr = wr_ok && mmio_hit;

    dmem_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .cnt_we  (tmr_wr && off == OFF_TIMER_CNT),
        .ctrl_we (tmr_wr && off == OFF_TIMER_CTRL),
        .load_we (tmr_wr && off == OFF_TIMER_LOAD),
        .wdata   (writedataM),
        .cnt     (tmr_cnt),
        .load    (tmr_load),
        .ctrl    (tmr_ctrl),
        .irq     (timer_irq)
    );
`else
    assign tmr_cnt   = '0;
    assign tmr_load  = '0;
    assign tmr_ctrl  = '0;
    assign timer_irq = 1'b0;
`endif

    // NOTE: readdataM gets a default first so no path through the mux infers a latch.
    always_comb begin
        readdataM = '0;
        if (ram_hit) begin
            readdataM = ram[word_idx];
        end else if (mmio_hit) begin
            case (off)
                OFF_CYCLE_LO:   readdataM = cycle_cnt[31:0];
                OFF_CYCLE_HI:   readdataM = cycle_cnt[63:32];
                OFF_TIMER_CNT:  readdataM = tmr_cnt;
                OFF_TIMER_CTRL: readdataM = tmr_ctrl;
                OFF_TIMER_LOAD: readdataM = tmr_load;
                OFF_GPIO_OUT:   readdataM = 32'(gpio_q);
                default:        readdataM = '0;
            endcase
        end
    end

    assign gpio_out = gpio_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: a directed vector table, hand sequences for
// timer and reset corners, then random traffic against an address-level model.
module tb_dmem_bridge;

    localparam int          RAM_WORDS = 1024;
    localparam int          GPIO_W    = 8;
    localparam logic [31:0] RAM_BYTES = 32'h0000_1000;
    localparam logic [31:0] BASE      = 32'h1000_0000;
    localparam logic [31:0] A_CLO     = BASE;
    localparam logic [31:0] A_CHI     = BASE + 32'h4;
    localparam logic [31:0] A_CNT     = BASE + 32'h8;
    localparam logic [31:0] A_CTRL    = BASE + 32'hC;
    localparam logic [31:0] A_LOAD    = BASE + 32'h10;
    localparam logic [31:0] A_GPIO    = BASE + 32'h14;

`ifdef DMEM_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              memwriteM;
    logic [31:0]       aluoutM;
    logic [31:0]       writedataM;
    logic [31:0]       readdataM;
    logic [GPIO_W-1:0] gpio_out;
    logic              timer_irq;
    logic              bus_err;

    dmem_bridge #(.RAM_WORDS(RAM_WORDS), .GPIO_W(GPIO_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .memwriteM  (memwriteM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .gpio_out   (gpio_out),
        .timer_irq  (timer_irq),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef enum {K_RAM, K_CLO, K_CHI, K_TCNT, K_TCTRL, K_TLOAD, K_GPIO, K_UNUSED, K_UNMAPPED} kind_e;

    // Reference model state, kept at the level of software-visible registers.
    bit                model_ok = 1'b0;
    logic [31:0]       m_ram [int];
    logic [63:0]       m_cycle;
    logic [31:0]       m_cnt;
    logic [31:0]       m_load;
    bit                m_en, m_ar, m_flag, m_irqen, m_berr;
    logic [GPIO_W-1:0] m_gpio;

    function automatic kind_e classify(input logic [31:0] a);
        logic [31:0] rel;
        if (a < RAM_BYTES) return K_RAM;
        rel = a - BASE;
        if (a >= BASE && rel < 32'd32) begin
            case (int'(rel >> 2))
                0:       return K_CLO;
                1:       return K_CHI;
                2:       return TIMER_EN ? K_TCNT  : K_UNUSED;
                3:       return TIMER_EN ? K_TCTRL : K_UNUSED;
                4:       return TIMER_EN ? K_TLOAD : K_UNUSED;
                5:       return K_GPIO;
                default: return K_UNUSED;
            endcase
        end
        return K_UNMAPPED;
    endfunction

    function automatic logic [31:0] t(input logic [31:0] v);
        return TIMER_EN ? v : 32'h0;
    endfunction

    task automatic model_read(input logic [31:0] a, output logic [31:0] exp, output bit known);
        known = 1'b1;
        exp   = 32'h0;
        case (classify(a))
            K_RAM: begin
                known = m_ram.exists(int'(a >> 2));
                if (known) exp = m_ram[int'(a >> 2)];
            end
            K_CLO:   exp = m_cycle[31:0];
            K_CHI:   exp = m_cycle[63:32];
            K_TCNT:  exp = m_cnt;
            K_TCTRL: exp = {28'h0, m_irqen, m_flag, m_ar, m_en};
            K_TLOAD: exp = m_load;
            K_GPIO:  exp = 32'(m_gpio);
            default: exp = 32'h0;
        endcase
    endtask

    task automatic model_edge(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
        kind_e       k;
        bit          illegal, ok, expire;
        logic [31:0] nxt;
        if (r) begin
            model_ok = 1'b1;
            m_cycle  = '0;
            m_cnt    = '0;
            m_load   = '0;
            m_en     = 1'b0;
            m_ar     = 1'b0;
            m_flag   = 1'b0;
            m_irqen  = 1'b0;
            m_gpio   = '0;
            m_berr   = 1'b0;
            return;
        end
        k       = classify(a);
        illegal = we && (a[1:0] != 2'b00 || k inside {K_UNMAPPED, K_CLO, K_CHI});
        ok      = we && !illegal;
        expire  = 1'b0;
        nxt     = m_cnt;
        if (m_en && m_cnt != 0) begin
            if (m_cnt == 1) begin
                expire = 1'b1;
                nxt    = m_ar ? m_load : 32'h0;
            end else begin
                nxt = m_cnt - 1;
            end
        end
        if (ok) begin
            case (k)
                K_RAM:   m_ram[int'(a >> 2)] = d;
                K_TCNT:  nxt = d;
                K_TLOAD: m_load = d;
                K_TCTRL: begin
                    m_en    = d[0];
                    m_ar    = d[1];
                    m_irqen = d[3];
                    if (d[2]) m_flag = 1'b0;
                end
                K_GPIO:  m_gpio = d[GPIO_W-1:0];
                default: ;
            endcase
        end
        if (expire) m_flag = 1'b1;
        m_cnt   = nxt;
        m_berr  = m_berr | illegal;
        m_cycle = m_cycle + 64'd1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
        rst        = r;
        memwriteM  = we;
        aluoutM    = a;
        writedataM = d;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge(rst, memwriteM, aluoutM, writedataM);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp;
        bit          known;
        if (!model_ok) return;
        model_read(aluoutM, exp, known);
        if (known) check({tag, " rd"}, readdataM, exp);
        check({tag, " gpio"}, 32'(gpio_out), 32'(m_gpio));
        check({tag, " irq"}, 32'(timer_irq), 32'(m_flag & m_irqen));
        check({tag, " berr"}, 32'(bus_err), 32'(m_berr));
    endtask

    task automatic cyc(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d, input string tag);
        apply(r, we, a, d);
        check_model(tag);
        edge_step();
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 32'h0, 32'h0);
        edge_step();
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_gpio;
        bit          exp_berr;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] exp_cnt [7];

    initial begin
        // Row i is cycle i after reset release.
        vecs[0]  = '{1'b0, A_CLO,         32'h0,         1'b1, 32'h0,         8'h00, 1'b0};
        vecs[1]  = '{1'b1, 32'h10,        32'h1111_1111, 1'b0, 32'h0,         8'h00, 1'b0};
        vecs[2]  = '{1'b1, 32'h10,        32'hDEAD_BEEF, 1'b1, 32'h1111_1111, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 32'h10,        32'h0,         1'b1, 32'hDEAD_BEEF, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 32'h13,        32'h0,         1'b1, 32'hDEAD_BEEF, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, A_CLO,         32'h0,         1'b1, 32'd5,         8'h00, 1'b0};
        vecs[6]  = '{1'b0, A_CHI,         32'h0,         1'b1, 32'h0,         8'h00, 1'b0};
        vecs[7]  = '{1'b1, A_GPIO,        32'h1A5,       1'b1, 32'h0,         8'h00, 1'b0};
        vecs[8]  = '{1'b0, A_GPIO,        32'h0,         1'b1, 32'hA5,        8'hA5, 1'b0};
        vecs[9]  = '{1'b0, BASE + 32'h18, 32'h0,         1'b1, 32'h0,         8'hA5, 1'b0};
        vecs[10] = '{1'b0, 32'h2000_0000, 32'h0,         1'b1, 32'h0,         8'hA5, 1'b0};
        vecs[11] = '{1'b0, RAM_BYTES,     32'h0,         1'b1, 32'h0,         8'hA5, 1'b0};
        vecs[12] = '{1'b1, BASE + 32'h20, 32'h5,         1'b1, 32'h0,         8'hA5, 1'b0};
        vecs[13] = '{1'b0, A_CLO,         32'h0,         1'b1, 32'd13,        8'hA5, 1'b1};
        exp_cnt  = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd4, 32'd3, 32'd2};

        rst = 1'b1; memwriteM = 1'b0; aluoutM = '0; writedataM = '0;
        @(negedge clk);
        do_reset();
        do_reset();

        for (int i = 0; i < 14; i++) begin
            apply(1'b0, vecs[i].we, vecs[i].addr, vecs[i].data);
            if (vecs[i].chk_rd) check($sformatf("tbl%0d rd", i), readdataM, vecs[i].exp_rd);
            check($sformatf("tbl%0d gpio", i), 32'(gpio_out), 32'(vecs[i].exp_gpio));
            check($sformatf("tbl%0d berr", i), 32'(bus_err), 32'(vecs[i].exp_berr));
            check($sformatf("tbl%0d irq", i), 32'(timer_irq), 32'h0);
            edge_step();
        end

        // Illegal writes: suppressed, sticky bus_err until reset.
        do_reset();
        cyc(1'b0, 1'b1, 32'h11, 32'h0BAD_0BAD, "ill_mis_wr");
        apply(1'b0, 1'b0, 32'h10, 32'h0);
        check("ill_mis ram", readdataM, 32'hDEAD_BEEF);
        check("ill_mis berr", 32'(bus_err), 32'h1);
        edge_step();
        repeat (3) cyc(1'b0, 1'b0, 32'h10, 32'h0, "ill_sticky");
        do_reset();
        cyc(1'b0, 1'b1, 32'h2000_0000, 32'hFFFF_FFFF, "ill_unm_wr");
        apply(1'b0, 1'b0, A_GPIO, 32'h0);
        check("ill_unm berr", 32'(bus_err), 32'h1);
        check("ill_unm gpio", 32'(gpio_out), 32'h0);
        edge_step();
        do_reset();
        cyc(1'b0, 1'b1, A_CLO, 32'h1234_5678, "ill_cyc_wr");
        apply(1'b0, 1'b0, A_CLO, 32'h0);
        check("ill_cyc lo", readdataM, 32'd1);
        check("ill_cyc berr", 32'(bus_err), 32'h1);
        edge_step();

        // GPIO truncation, then reset discarding same-cycle writes.
        do_reset();
        cyc(1'b0, 1'b1, A_GPIO, 32'h1A5, "gp_wr");
        apply(1'b0, 1'b0, A_GPIO, 32'h0);
        check("gp out", 32'(gpio_out), 32'hA5);
        check("gp rd", readdataM, 32'hA5);
        edge_step();
        apply(1'b1, 1'b1, A_GPIO, 32'hFF);
        edge_step();
        apply(1'b0, 1'b0, A_GPIO, 32'h0);
        check("gp rst out", 32'(gpio_out), 32'h0);
        check("gp rst rd", readdataM, 32'h0);
        edge_step();
        apply(1'b1, 1'b1, 32'h10, 32'h0);
        edge_step();
        apply(1'b0, 1'b0, 32'h10, 32'h0);
        check("rst ram wr dropped", readdataM, 32'hDEAD_BEEF);
        edge_step();

        // One-shot timer.
        do_reset();
        cyc(1'b0, 1'b1, A_CNT, 32'd3, "os_cnt_wr");
        apply(1'b0, 1'b1, A_CTRL, 32'h9);
        check("os ctrl old", readdataM, 32'h0);
        edge_step();
        apply(1'b0, 1'b0, A_CNT, 32'h0);  check("os cnt3", readdataM, t(3));  edge_step();
        apply(1'b0, 1'b0, A_CNT, 32'h0);  check("os cnt2", readdataM, t(2));  edge_step();
        apply(1'b0, 1'b0, A_CTRL, 32'h0);
        check("os ctrl pre", readdataM, t(32'h9));
        check("os irq pre", 32'(timer_irq), 32'h0);
        edge_step();
        apply(1'b0, 1'b0, A_CTRL, 32'h0);
        check("os ctrl flag", readdataM, t(32'hD));
        check("os irq", 32'(timer_irq), t(1));
        edge_step();
        apply(1'b0, 1'b0, A_CNT, 32'h0);
        check("os cnt0", readdataM, 32'h0);
        check("os irq hold", 32'(timer_irq), t(1));
        edge_step();
        cyc(1'b0, 1'b1, A_CTRL, 32'hD, "os_clr_wr");
        apply(1'b0, 1'b0, A_CTRL, 32'h0);
        check("os ctrl clr", readdataM, t(32'h9));
        check("os irq clr", 32'(timer_irq), 32'h0);
        edge_step();
        cyc(1'b0, 1'b0, A_CNT, 32'h0, "os_hold");

        // Autoreload with period 4, and a clear landing on an expiry.
        do_reset();
        cyc(1'b0, 1'b1, A_LOAD, 32'd4, "ar_load");
        cyc(1'b0, 1'b1, A_CNT, 32'd4, "ar_cnt");
        cyc(1'b0, 1'b1, A_CTRL, 32'hB, "ar_ctrl");
        for (int i = 0; i < 7; i++) begin
            apply(1'b0, 1'b0, A_CNT, 32'h0);
            check($sformatf("ar cnt%0d", i), readdataM, t(exp_cnt[i]));
            edge_step();
        end
        apply(1'b0, 1'b1, A_CTRL, 32'hF);
        check("ar ctrl before clr", readdataM, t(32'hF));
        edge_step();
        apply(1'b0, 1'b0, A_CTRL, 32'h0);
        check("ar clr vs expiry", readdataM, t(32'hF));
        check("ar irq kept", 32'(timer_irq), t(1));
        edge_step();
        cyc(1'b0, 1'b1, A_CTRL, 32'hF, "ar_clr_wr");
        apply(1'b0, 1'b0, A_CTRL, 32'h0);
        check("ar cleared", readdataM, t(32'hB));
        check("ar irq cleared", 32'(timer_irq), 32'h0);
        edge_step();
        apply(1'b0, 1'b0, A_CNT, 32'h0);  check("ar cnt1", readdataM, t(1));  edge_step();
        apply(1'b0, 1'b0, A_CTRL, 32'h0);
        check("ar flag reset", readdataM, t(32'hF));
        check("ar irq again", 32'(timer_irq), t(1));
        edge_step();

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bit          r, we;
            logic [31:0] a, d;
            r  = ($urandom_range(0, 99) == 0);
            we = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 32'($urandom_range(0, 15)) << 2;
                4, 5, 6, 7: a = BASE + (32'($urandom_range(0, 7)) << 2);
                8: begin
                    case ($urandom_range(0, 3))
                        0:       a = 32'h2000_0000;
                        1:       a = BASE + 32'h20;
                        2:       a = RAM_BYTES;
                        default: a = 32'hFFFF_FFFC;
                    endcase
                end
                default: a = 32'($urandom_range(0, 63));
            endcase
            d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
            cyc(r, we, a, d, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
